warp_scheduler: RTL and testbench
=================================

WARP_SCHEDULER -- requirements
Module: warp_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4: number of warp-launch requesters.
REQ-002 Parameter DEPTH, default 8: warp queue entries; a power of two, at least 2.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  NUM_REQ  per-requester launch request.
REQ-006 req_warp  in  NUM_REQ x warp_reg_t  per-requester warp descriptor.
REQ-007 req_grant  out  NUM_REQ  one-hot combinational grant; the warp is enqueued at the next edge.
REQ-008 issue_valid  out  1  a warp is offered to the core.
REQ-009 issue_warp  out  warp_reg_t  offered warp, registered.
REQ-010 issue_ready  in  1  the core accepts the offered warp.
REQ-011 core_done  in  1  the running warp has finished its slot.
REQ-012 core_yield  in  1  qualifies core_done; present only when WARP_SCHED_REQUEUE_EN is defined.
REQ-013 queue_count  out  $clog2(DEPTH+1)  number of occupied queue entries.
REQ-014 queue_full  out  1  high when queue_count == DEPTH.
REQ-015 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-016 Arbitration SHALL be round-robin: the search starts at index rr_ptr, and rr_ptr becomes granted index + 1 (mod NUM_REQ) at the edge after a grant.
REQ-017 At most one grant SHALL be made per cycle, and only when req_valid is high for that requester and the registered queue_count is below the admit limit.
REQ-018 The admit limit SHALL be DEPTH; with WARP_SCHED_REQUEUE_EN, it SHALL be DEPTH-1 while the FSM is in RUN.
REQ-019 Full-queue rule: when queue_count == DEPTH, no grant SHALL be made, even if a pop occurs in the same cycle.
REQ-020 Queue behaviour: FIFO order; head and tail pointers wrap modulo DEPTH; a push writes at tail and a pop advances head.
REQ-021 On a simultaneous push and pop, both SHALL occur and queue_count SHALL remain unchanged.
REQ-022 FSM states SHALL be IDLE, ISSUE and RUN.
REQ-023 IDLE -> ISSUE at the next edge when queue_count > 0; issue_warp SHALL load the head entry on that same edge.
REQ-024 In ISSUE, issue_valid SHALL be 1 and issue_warp SHALL be held stable until issue_ready is sampled high.
REQ-025 An ISSUE handshake (issue_valid and issue_ready) SHALL pop the head, capture the warp into run_warp, and move to RUN.
REQ-026 In RUN, core_done SHALL cause a transition to IDLE at the next edge.
REQ-027 Minimum latency SHALL be: grant at cycle N, issue_valid at N+2, and a back-to-back re-issue at the earliest two cycles after core_done.
REQ-028 core_done outside RUN and issue_ready outside ISSUE SHALL be ignored.
REQ-029 issue_valid SHALL NOT be asserted in IDLE or RUN.

Reset
REQ-030 On rst, outputs SHALL reset as follows: req_grant=0, issue_valid=0, issue_warp=0, queue_count=0, queue_full=0, busy=0.
REQ-031 On rst, internal state SHALL reset as follows: rr_ptr=0, head=0, tail=0, FSM=IDLE, run_warp=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued and running warps with no handshake.

Configuration
REQ-033 Macro WARP_SCHED_REQUEUE_EN: when defined, core_done together with core_yield in RUN SHALL push run_warp at tail at that edge, and that cycle's external grant SHALL be suppressed.
REQ-034 WARP_SCHED_REQUEUE_EN: the reserved slot from REQ-018 SHALL guarantee the requeue never overflows the queue.
REQ-035 When WARP_SCHED_REQUEUE_EN is undefined, the core_yield port and the requeue logic SHALL be absent; core_done always retires the warp.

Structure
REQ-036 The shared package gpu_pkg SHALL hold warp_reg_t (warp id, PC) and the FSM state enum.
REQ-037 Round-robin arbitration SHALL live in a sub-module rr_arbiter (parameter NUM_REQ; ports req, ptr, grant); queue storage SHALL stay inline.

Verification
REQ-038 Single request: req_valid=0001 with warp 8'h01 -> grant 0001, issue_valid two cycles later with issue_warp=8'h01.
REQ-039 Fairness: req_valid=1111 held, issue_ready=0 -> grants in order 0,1,2,3,0,...; queue_full after 8 grants with no further grants.
REQ-040 Wrap-around: push 8, issue/done 3, push 3 more -> warps issued in push order; queue_count never exceeds 8.
REQ-041 Simultaneous: queue_count=5, push and ISSUE pop in the same cycle -> queue_count stays 5.
REQ-042 Reset mid-RUN with queue_count=4 -> all outputs 0 and FSM IDLE; a subsequent request is issued normally.
REQ-043 With WARP_SCHED_REQUEUE_EN, queue at DEPTH-1 in RUN, core_done and core_yield with warp 8'h05 -> 8'h05 at tail, queue_full=1, no external grant that cycle.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types for the warp scheduler.
//   warp_reg_t    : packed warp descriptor {warp_id, pc}, 8 bits total
//   sched_state_t : scheduler FSM states IDLE / ISSUE / RUN
//   idx_width     : helper giving a safe index width (at least 1 bit)
package gpu_pkg;

    localparam int WARP_ID_W = 4;
    localparam int PC_W      = 4;

    typedef struct packed {
        logic [WARP_ID_W-1:0] warp_id;
        logic [PC_W-1:0]      pc;
    } warp_reg_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/warp_scheduler_if.sv
// Bus bundle between warp requesters / core and the warp scheduler.
//   req_valid/req_warp/req_grant : per-requester launch request and one-hot grant
//   issue_valid/issue_warp/issue_ready : warp offer handshake to the core
//   core_done (+ core_yield when WARP_SCHED_REQUEUE_EN is defined) : slot end
//   queue_count/queue_full/busy : status
// Modports: slave = scheduler side, master = requester/core side.
// Optional feature macro: WARP_SCHED_REQUEUE_EN (adds core_yield).
interface warp_scheduler_if
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0]            req_valid;
    warp_reg_t [NUM_REQ-1:0]       req_warp;
    logic [NUM_REQ-1:0]            req_grant;
    logic                          issue_valid;
    warp_reg_t                     issue_warp;
    logic                          issue_ready;
    logic                          core_done;
`ifdef WARP_SCHED_REQUEUE_EN
    logic                          core_yield;
`endif
    logic [CW-1:0]                 queue_count;
    logic                          queue_full;
    logic                          busy;

`ifdef WARP_SCHED_REQUEUE_EN
    modport slave (
        input  req_valid, req_warp, issue_ready, core_done, core_yield,
        output req_grant, issue_valid, issue_warp, queue_count, queue_full, busy
    );
    modport master (
        output req_valid, req_warp, issue_ready, core_done, core_yield,
        input  req_grant, issue_valid, issue_warp, queue_count, queue_full, busy
    );
`else
    modport slave (
        input  req_valid, req_warp, issue_ready, core_done,
        output req_grant, issue_valid, issue_warp, queue_count, queue_full, busy
    );
    modport master (
        output req_valid, req_warp, issue_ready, core_done,
        input  req_grant, issue_valid, issue_warp, queue_count, queue_full, busy
    );
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : request vector
//   ptr   : index where the priority search starts
//   grant : one-hot grant of the first requester at or after ptr (wrapping)
module rr_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int PTR_W  = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s -= NUM_REQ;
        return PTR_W'(s);
    endfunction

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = wrap_add(ptr, i);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/warp_scheduler.sv
// Warp scheduler: round-robin admission of warp launch requests into a FIFO
// warp queue, then one-at-a-time issue to the core through an IDLE/ISSUE/RUN FSM.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : warp_scheduler_if.slave (requests, grants, issue handshake, status)
// Optional feature macro: WARP_SCHED_REQUEUE_EN -- core_done with core_yield in
// RUN pushes the running warp back at the queue tail; one slot is held in
// reserve during RUN so that push can never overflow.
module warp_scheduler
    import gpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    warp_scheduler_if.slave  bus
);

    localparam int PTR_W = idx_width(NUM_REQ);
    localparam int AW    = idx_width(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    sched_state_t     state_reg, state_next;
    logic [AW-1:0]    head_reg, tail_reg;
    logic [CW-1:0]    count_reg;
    logic [PTR_W-1:0] rr_ptr_reg;
    warp_reg_t        issue_warp_reg;
    warp_reg_t        queue_mem [DEPTH];

    logic [CW-1:0]      admit_limit;
    logic               admit;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    warp_reg_t          grant_warp;
    logic               ext_push;
    logic               push;
    warp_reg_t          push_data;
    logic               pop;
    logic               load_issue;
    logic               requeue;

`ifdef WARP_SCHED_REQUEUE_EN
    warp_reg_t run_warp_reg;

    assign requeue = (state_reg == ST_RUN) && bus.core_done && bus.core_yield;

    // One entry stays reserved while a warp runs so its requeue always fits.
    always_comb begin
        admit_limit = DEPTH_C;
        if (state_reg == ST_RUN) admit_limit = DEPTH_C - CW'(1);
    end
`else
    // Without requeue the running warp is never needed again; issue_warp_reg
    // keeps its value through RUN, so no separate run_warp copy is held.
    assign requeue     = 1'b0;
    assign admit_limit = DEPTH_C;
`endif

    // Compare against the registered count only: a pop in the same cycle does
    // not open a slot, so a full queue never admits.
    assign admit   = !rst && (count_reg < admit_limit) && !requeue;
    assign arb_req = bus.req_valid & {NUM_REQ{admit}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_reg),
        .grant (grant)
    );

    always_comb begin
        grant_idx  = '0;
        grant_warp = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = PTR_W'(i);
                grant_warp = bus.req_warp[i];
            end
        end
    end

    assign ext_push = |grant;
    assign push     = ext_push || requeue;
    assign pop      = (state_reg == ST_ISSUE) && bus.issue_ready;

`ifdef WARP_SCHED_REQUEUE_EN
    assign push_data = requeue ? run_warp_reg : grant_warp;
`else
    assign push_data = grant_warp;
`endif

    always_comb begin
        state_next = state_reg;
        load_issue = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (count_reg != '0) begin
                    state_next = ST_ISSUE;
                    load_issue = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (bus.issue_ready) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (bus.core_done) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            rr_ptr_reg     <= '0;
            issue_warp_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (push) tail_reg <= tail_reg + AW'(1);
            if (pop)  head_reg <= head_reg + AW'(1);
            if (push && !pop)      count_reg <= count_reg + CW'(1);
            else if (pop && !push) count_reg <= count_reg - CW'(1);
            if (ext_push) begin
                if (grant_idx == PTR_W'(NUM_REQ - 1)) rr_ptr_reg <= '0;
                else                                  rr_ptr_reg <= grant_idx + PTR_W'(1);
            end
            if (load_issue) issue_warp_reg <= queue_mem[head_reg];
        end
    end

`ifdef WARP_SCHED_REQUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      run_warp_reg <= '0;
        else if (pop) run_warp_reg <= issue_warp_reg;
    end
`endif

    // Queue storage has no reset so it maps onto RAM; pointers alone define content.
    always_ff @(posedge clk) begin
        if (push) queue_mem[tail_reg] <= push_data;
    end

    assign bus.req_grant   = grant;
    assign bus.issue_valid = (state_reg == ST_ISSUE);
    assign bus.issue_warp  = issue_warp_reg;
    assign bus.queue_count = count_reg;
    assign bus.queue_full  = (count_reg == DEPTH_C);
    assign bus.busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized self-checking bench for warp_scheduler against a queue-based
// reference model. Define WARP_SCHED_REQUEUE_EN to exercise the requeue build.
module tb_warp_scheduler;
    import gpu_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 8;
`ifdef WARP_SCHED_REQUEUE_EN
    localparam bit REQUEUE = 1'b1;
`else
    localparam bit REQUEUE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    warp_scheduler_if #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) bus ();

    warp_scheduler #(.NUM_REQ(NUM_REQ), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model: queue contents, round-robin pointer, offered and running warps.
    warp_reg_t mq[$];
    int        m_rr;
    bit        m_offer;
    warp_reg_t m_offer_warp;
    bit        m_run;
    warp_reg_t m_run_warp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr         = 0;
        m_offer      = 1'b0;
        m_offer_warp = '0;
        m_run        = 1'b0;
        m_run_warp   = '0;
    endtask

    task automatic drive_idle();
        bus.req_valid   = '0;
        for (int i = 0; i < NUM_REQ; i++) bus.req_warp[i] = '0;
        bus.issue_ready = 1'b0;
        bus.core_done   = 1'b0;
`ifdef WARP_SCHED_REQUEUE_EN
        bus.core_yield  = 1'b0;
`endif
    endtask

    // Assert reset between edges with busy inputs; everything must read zero.
    task automatic apply_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.req_valid   = '1;
        bus.issue_ready = 1'b1;
        bus.core_done   = 1'b1;
        #1;
        check("rst_grant",       32'(bus.req_grant),   32'd0);
        check("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        check("rst_issue_warp",  32'(bus.issue_warp),  32'd0);
        check("rst_count",       32'(bus.queue_count), 32'd0);
        check("rst_full",        32'(bus.queue_full),  32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        model_reset();
    endtask

    // One clock cycle: drive inputs, compare DUT against model, advance model.
    task automatic step(input logic [NUM_REQ-1:0] rv, input bit rdy, input bit done,
                        input bit yld, input int w0);
        logic [NUM_REQ-1:0] exp_g;
        int                 g;
        int                 limit;
        bit                 requeue;
        @(negedge clk);
        bus.req_valid = rv;
        for (int i = 0; i < NUM_REQ; i++) bus.req_warp[i] = warp_reg_t'(8'($urandom_range(0, 255)));
        if (w0 >= 0) bus.req_warp[0] = warp_reg_t'(8'(w0));
        bus.issue_ready = rdy;
        bus.core_done   = done;
`ifdef WARP_SCHED_REQUEUE_EN
        bus.core_yield  = yld;
`endif
        #1;
        requeue = REQUEUE && m_run && done && yld;
        limit   = (REQUEUE && m_run) ? DEPTH - 1 : DEPTH;
        exp_g   = '0;
        g       = -1;
        if (!requeue && mq.size() < limit) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && rv[(m_rr + k) % NUM_REQ]) g = (m_rr + k) % NUM_REQ;
            end
        end
        if (g >= 0) exp_g[g] = 1'b1;

        check("grant",       32'(bus.req_grant),   32'(exp_g));
        check("issue_valid", 32'(bus.issue_valid), 32'(m_offer));
        if (m_offer) check("issue_warp", 32'(bus.issue_warp), 32'(m_offer_warp));
        check("queue_count", 32'(bus.queue_count), 32'(mq.size()));
        check("queue_full",  32'(bus.queue_full),  32'(mq.size() == DEPTH));
        check("busy",        32'(bus.busy),        32'(m_offer || m_run));

        if (!m_offer && !m_run) begin
            if (mq.size() > 0) begin
                m_offer      = 1'b1;
                m_offer_warp = mq[0];
            end
        end else if (m_offer) begin
            if (rdy) begin
                $display("issue warp=%02h queue=%0d", m_offer_warp, mq.size() - 1);
                void'(mq.pop_front());
                m_run_warp = m_offer_warp;
                m_offer    = 1'b0;
                m_run      = 1'b1;
            end
        end else if (done) begin
            m_run = 1'b0;
            if (requeue) mq.push_back(m_run_warp);
        end
        if (g >= 0) begin
            mq.push_back(bus.req_warp[g]);
            m_rr = (g + 1) % NUM_REQ;
        end
    endtask

    initial begin
        int  budget;
        bit  reached;
        drive_idle();
        model_reset();
        apply_reset();

        // Single request from requester 0 with warp 8'h01, then watch it issue.
        step(4'b0001, 1'b0, 1'b0, 1'b0, 8'h01);
        step(4'b0000, 1'b0, 1'b0, 1'b0, -1);
        step(4'b0000, 1'b1, 1'b0, 1'b0, -1);
        step(4'b0000, 1'b0, 1'b1, 1'b0, -1);
        step(4'b0000, 1'b0, 1'b0, 1'b0, -1);

        // Fairness and full queue: all requesting, core never accepts.
        repeat (14) step('1, 1'b0, 1'b0, 1'b0, -1);

        // Drain through the core, then randomized traffic.
        repeat (30) step('0, 1'b1, 1'b1, 1'b0, -1);
        for (int c = 0; c < 500; c++) begin
            step(NUM_REQ'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), -1);
        end

        // Reach RUN with at least four queued warps, then reset mid-operation.
        reached = 1'b0;
        budget  = 0;
        while (!reached && budget < 60) begin
            step('1, 1'b1, 1'b0, 1'b0, -1);
            reached = m_run && (mq.size() >= 4);
            budget++;
        end
        check("reach_run_q4", 32'(reached), 32'd1);
        apply_reset();

        // A fresh request after reset issues normally.
        step(4'b0100, 1'b0, 1'b0, 1'b0, -1);
        repeat (4) step('0, 1'b1, 1'b0, 1'b0, -1);
        step('0, 1'b0, 1'b1, 1'b0, -1);
        for (int c = 0; c < 150; c++) begin
            step(NUM_REQ'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), -1);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
